// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    localparam int unsigned DEFAULT_NREQ    = 4;
    localparam int unsigned DEFAULT_DW      = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 4096;

    // Index following i on a ring of n entries.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter-side signals of the UART transmit scheduler.
interface uart_tx_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_done;
    logic [NREQ-1:0]    req_err;
    logic               tx_newd;
    logic [DW-1:0]      tx_data;
    logic               tx_line;
    logic               tx_done;
    logic               busy;
    logic [IW-1:0]      grant_id;

    // Requesters plus the transmitter side of the link.
    modport master (
        output req_valid, req_data, tx_line, tx_done,
        input  req_ready, req_done, req_err, tx_newd, tx_data, busy, grant_id
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_data, tx_line, tx_done,
        output req_ready, req_done, req_err, tx_newd, tx_data, busy, grant_id
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin winner select over req_valid starting at ptr; ptr moves past each grant.
module uart_rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = DEFAULT_NREQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic                    grant,
    output logic [$clog2(NREQ)-1:0] win_c,
    output logic                    any_c
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] ptr;
    int            idx;

    // Scan from the far end back toward ptr so the closest valid requester wins.
    always_comb begin
        win_c = '0;
        any_c = 1'b0;
        idx   = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            if (req_valid[IW'(idx)]) begin
                win_c = IW'(idx);
                any_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= IW'(wrap_inc(int'(win_c), int'(NREQ)));
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NREQ byte requesters: grant, load, confirm start bit, await done.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = DEFAULT_NREQ,
    parameter int unsigned DW      = DEFAULT_DW,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.slave bus
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT);

    sched_state_e    state, state_nxt;
    logic [NREQ-1:0] ready_q, ready_nxt;
    logic [NREQ-1:0] fin_q, fin_nxt;
    logic [NREQ-1:0] err_q, err_nxt;
    logic            newd_q, newd_nxt;
    logic [DW-1:0]   data_q, data_nxt;
    logic [IW-1:0]   gid_q, gid_nxt;
    logic            busy_q;
    logic            armed, armed_nxt;
    logic [TW-1:0]   timer, timer_nxt;

    logic            line_s1, line_s;
    logic            done_s1, done_s, done_d;
    logic            done_rise_c;
    logic            expire_c;
    logic            grant_c;
    logic [IW-1:0]   win_c;
    logic            any_c;

    assign bus.req_ready = ready_q;
    assign bus.req_done  = fin_q;
    assign bus.req_err   = err_q;
    assign bus.tx_newd   = newd_q;
    assign bus.tx_data   = data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = gid_q;

    assign done_rise_c = done_s & ~done_d;
    assign expire_c    = (timer == TW'(TIMEOUT - 1));

    uart_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (bus.req_valid),
        .grant     (grant_c),
        .win_c     (win_c),
        .any_c     (any_c)
    );

    // Two-flop synchronizers; line idles high so it resets to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_s1 <= 1'b1;
            line_s  <= 1'b1;
            done_s1 <= 1'b0;
            done_s  <= 1'b0;
            done_d  <= 1'b0;
        end else begin
            line_s1 <= bus.tx_line;
            line_s  <= line_s1;
            done_s1 <= bus.tx_done;
            done_s  <= done_s1;
            done_d  <= done_s;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_nxt = state;
        ready_nxt = '0;
        fin_nxt   = '0;
        err_nxt   = '0;
        newd_nxt  = newd_q;
        data_nxt  = data_q;
        gid_nxt   = gid_q;
        armed_nxt = armed;
        timer_nxt = timer;
        grant_c   = 1'b0;
        case (state)
            IDLE: begin
                if (any_c) begin
                    grant_c          = 1'b1;
                    data_nxt         = bus.req_data[int'(DW) * int'(win_c) +: DW];
                    gid_nxt          = win_c;
                    ready_nxt[win_c] = 1'b1;
                    armed_nxt        = 1'b0;
                    timer_nxt        = '0;
                    newd_nxt         = 1'b1;
                    state_nxt        = LOAD;
                end
            end
            LOAD: begin
                timer_nxt = timer + TW'(1);
                if (line_s) begin
                    armed_nxt = 1'b1;
                end
                // A low line only counts as our start bit once idle-high was observed.
                if (armed && !line_s) begin
                    newd_nxt  = 1'b0;
                    state_nxt = SEND;
                end else if (expire_c) begin
                    err_nxt[gid_q] = 1'b1;
                    newd_nxt       = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            SEND: begin
                timer_nxt = timer + TW'(1);
                newd_nxt  = 1'b0;
                if (done_rise_c) begin
                    fin_nxt[gid_q] = 1'b1;
                    state_nxt      = DONE;
                end else if (expire_c) begin
                    err_nxt[gid_q] = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ready_q <= '0;
            fin_q   <= '0;
            err_q   <= '0;
            newd_q  <= 1'b0;
            data_q  <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            armed   <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            fin_q   <= fin_nxt;
            err_q   <= err_nxt;
            newd_q  <= newd_nxt;
            data_q  <= data_nxt;
            gid_q   <= gid_nxt;
            busy_q  <= (state_nxt != IDLE);
            armed   <= armed_nxt;
            timer   <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural UART transmitter on the serial side.
module tb_uart_tx_sched;
    import uart_ctrl_pkg::*;

    localparam int BITC = 4;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic       tx_en;
    logic       force_mode;
    logic       f_line;
    logic       f_done;
    logic       m_line;
    logic       m_done;
    logic       m_busy;
    logic [7:0] m_frame;
    int         m_done_cyc;

    int   done_cnt = 0;
    int   err_cnt = 0;
    logic viol = 1'b0;

    uart_tx_sched_if #(.NREQ(4), .DW(8)) bus ();

    uart_tx_sched #(
        .NREQ    (4),
        .DW      (8),
        .TIMEOUT (4096)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_line = force_mode ? f_line : m_line;
    assign bus.tx_done = force_mode ? f_done : m_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.req_done != 4'b0) done_cnt <= done_cnt + 1;
        if (bus.req_err != 4'b0) err_cnt <= err_cnt + 1;
        if ($countones(bus.req_ready) > 1 || $countones(bus.req_done) > 1 ||
            $countones(bus.req_err) > 1 ||
            (32'(|bus.req_ready) + 32'(|bus.req_done) + 32'(|bus.req_err)) > 32'd1)
            viol <= 1'b1;
    end

    // Transmitter model: start bit, 8 data bits LSB first, stop bit, then a donetx pulse.
    initial begin
        m_line = 1'b1;
        m_done = 1'b0;
        m_busy = 1'b0;
        m_frame = 8'h00;
        m_done_cyc = 0;
        forever begin
            @(negedge clk);
            if (tx_en && bus.tx_newd) begin
                m_busy  = 1'b1;
                m_frame = bus.tx_data;
                m_line  = 1'b0;
                repeat (BITC) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    m_line = m_frame[b];
                    repeat (BITC) @(negedge clk);
                end
                m_line = 1'b1;
                repeat (BITC) @(negedge clk);
                m_done = 1'b1;
                m_done_cyc = cyc;
                @(negedge clk);
                m_done = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // sel: 0 = req_ready, 1 = req_done, 2 = req_err; returns 0 if nothing pulsed in max_cyc.
    task automatic wait_vec(input int sel, input int max_cyc, output logic [3:0] v, output int at);
        v  = 4'b0;
        at = cyc;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            case (sel)
                0:       v = bus.req_ready;
                1:       v = bus.req_done;
                default: v = bus.req_err;
            endcase
            at = cyc;
            if (v != 4'b0) return;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_send();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy && !bus.tx_newd) return;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d vectors miscompared", n_err, n_vec);
        $fatal(1);
    end

    initial begin
        logic [3:0] v;
        int t_rdy, t_done, t_err, t0, base;
        int exp_ids [5];
        exp_ids = '{0, 1, 2, 3, 0};

        rst = 1'b0;
        tx_en = 1'b1;
        force_mode = 1'b0;
        f_line = 1'b1;
        f_done = 1'b0;
        bus.req_valid = 4'b0;
        bus.req_data = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_done", 32'(bus.req_done), 32'h0);
        check("rst_err", 32'(bus.req_err), 32'h0);
        check("rst_newd", 32'(bus.tx_newd), 32'h0);
        check("rst_txdata", 32'(bus.tx_data), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_gid", 32'(bus.grant_id), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single request
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid = 4'b0001;
        t0 = cyc;
        wait_vec(0, 10, v, t_rdy);
        check("t1_ready", 32'(v), 32'h1);
        check("t1_ready_lat", 32'(t_rdy - t0), 32'd1);
        check("t1_newd", 32'(bus.tx_newd), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'h1);
        check("t1_gid", 32'(bus.grant_id), 32'h0);
        bus.req_valid = 4'b0;
        wait_vec(1, 200, v, t_done);
        check("t1_done", 32'(v), 32'h1);
        check("t1_done_lat", 32'(t_done - m_done_cyc), 32'd3);
        check("t1_byte", 32'(m_frame), 32'hA5);
        @(negedge clk);
        check("t1_idle", 32'(bus.busy), 32'h0);

        // Round robin across all four requesters
        apply_reset();
        bus.req_data = 32'h1312_1110;
        bus.req_valid = 4'b1111;
        t_done = 0;
        for (int g = 0; g < 5; g++) begin
            wait_vec(0, 20, v, t_rdy);
            check($sformatf("rr_ready%0d", g), 32'(v), 32'(1) << exp_ids[g]);
            if (g > 0) check($sformatf("rr_gap%0d", g), 32'(t_rdy - t_done), 32'd2);
            if (g != 0) bus.req_valid[exp_ids[g]] = 1'b0;
            wait_vec(1, 200, v, t_done);
            check($sformatf("rr_done%0d", g), 32'(v), 32'(1) << exp_ids[g]);
            check($sformatf("rr_byte%0d", g), 32'(m_frame), 32'h10 + 32'(exp_ids[g]));
        end
        bus.req_valid = 4'b0;

        // Transmitter ignores newd: timeout, then the next requester is served
        apply_reset();
        tx_en = 1'b0;
        bus.req_data = 32'h0000_6655;
        bus.req_valid = 4'b0011;
        wait_vec(0, 10, v, t_rdy);
        check("to_ready0", 32'(v), 32'h1);
        bus.req_valid[0] = 1'b0;
        wait_vec(2, 5000, v, t_err);
        check("to_err0", 32'(v), 32'h1);
        check("to_err_lat", 32'(t_err - t_rdy), 32'd4096);
        check("to_newd_low", 32'(bus.tx_newd), 32'h0);
        tx_en = 1'b1;
        wait_vec(0, 10, v, t0);
        check("to_ready1", 32'(v), 32'h2);
        check("to_regrant_lat", 32'(t0 - t_err), 32'd1);
        bus.req_valid = 4'b0;
        wait_vec(1, 200, v, t_done);
        check("to_done1", 32'(v), 32'h2);
        check("to_byte1", 32'(m_frame), 32'h66);

        // Reset in the middle of a frame; its late donetx must be ignored
        bus.req_data[23:16] = 8'h3C;
        bus.req_valid = 4'b0100;
        wait_vec(0, 10, v, t_rdy);
        check("rs_ready2", 32'(v), 32'h4);
        bus.req_valid = 4'b0;
        wait_send();
        check("rs_in_send", 32'(dut.state), 32'(SEND));
        rst = 1'b0;
        #1;
        check("rs_ready", 32'(bus.req_ready), 32'h0);
        check("rs_done", 32'(bus.req_done), 32'h0);
        check("rs_err", 32'(bus.req_err), 32'h0);
        check("rs_newd", 32'(bus.tx_newd), 32'h0);
        check("rs_txdata", 32'(bus.tx_data), 32'h0);
        check("rs_busy", 32'(bus.busy), 32'h0);
        check("rs_gid", 32'(bus.grant_id), 32'h0);
        check("rs_state", 32'(dut.state), 32'(IDLE));
        base = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!m_busy) break;
        end
        repeat (5) @(negedge clk);
        check("rs_stale_done", 32'(done_cnt - base), 32'h0);
        check("rs_idle", 32'(bus.busy), 32'h0);

        // donetx rise lands in the same cycle as timer expiry
        tx_en = 1'b0;
        force_mode = 1'b1;
        f_line = 1'b1;
        f_done = 1'b0;
        bus.req_data[7:0] = 8'h77;
        bus.req_valid = 4'b0001;
        wait_vec(0, 10, v, t_rdy);
        check("co_ready0", 32'(v), 32'h1);
        bus.req_valid = 4'b0;
        base = err_cnt;
        while (cyc < t_rdy + 2) @(negedge clk);
        f_line = 1'b0;
        while (cyc < t_rdy + 20) @(negedge clk);
        check("co_in_send", 32'(dut.state), 32'(SEND));
        f_line = 1'b1;
        while (cyc < t_rdy + 4093) @(negedge clk);
        f_done = 1'b1;
        @(negedge clk);
        f_done = 1'b0;
        wait_vec(1, 10, v, t_done);
        check("co_done0", 32'(v), 32'h1);
        check("co_done_at", 32'(t_done - t_rdy), 32'd4096);
        repeat (3) @(negedge clk);
        check("co_no_err", 32'(err_cnt - base), 32'h0);
        force_mode = 1'b0;
        tx_en = 1'b1;

        // Requester 2 withdraws while 3 waits; 3 wins and the pointer wraps to 0
        bus.req_data[15:8] = 8'h81;
        bus.req_valid = 4'b0010;
        wait_vec(0, 10, v, t_rdy);
        check("wd_ready1", 32'(v), 32'h2);
        bus.req_valid = 4'b0;
        wait_send();
        bus.req_data[31:16] = 16'hC392;
        bus.req_valid = 4'b1100;
        repeat (3) @(negedge clk);
        bus.req_valid = 4'b1000;
        wait_vec(1, 200, v, t_done);
        check("wd_done1", 32'(v), 32'h2);
        wait_vec(0, 10, v, t_rdy);
        check("wd_ready3", 32'(v), 32'h8);
        check("wd_ptr", 32'(dut.u_arb.ptr), 32'h0);
        bus.req_valid = 4'b0;
        wait_vec(1, 200, v, t_done);
        check("wd_done3", 32'(v), 32'h8);
        check("wd_byte3", 32'(m_frame), 32'hC3);

        repeat (2) @(negedge clk);
        check("onehot_pulses", 32'(viol), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
